// File: rtl/ham_pkg.sv
// Shared types and Hamming bit-map helpers for the ECC decoder.
// HAM_SECDED_EN appends the overall parity bit (SEC -> SECDED).
package ham_pkg;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'd0,
        ERR_CORR   = 2'd1,
        ERR_DOUBLE = 2'd2
    } err_t;

`ifdef HAM_SECDED_EN
    localparam int SECDED_W = 1;
`else
    localparam int SECDED_W = 0;
`endif

    function automatic int par_w(input int data_w);
        int p;
        p = 1;
        while ((1 << p) < data_w + p + 1) p++;
        return p;
    endfunction

    function automatic logic is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Hamming position (1-based) carrying data bit idx
    function automatic int data_pos(input int idx);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        while (cnt <= idx) begin
            pos++;
            if (!is_pow2(pos)) cnt++;
        end
        return pos;
    endfunction

endpackage

// File: rtl/ham_syndrome.sv
// Combinational syndrome (and overall parity under HAM_SECDED_EN).
// Position i+1 contributes to syndrome bit k when bit k of i+1 is set.
module ham_syndrome
    import ham_pkg::*;
#(
    parameter  int DATA_W = 8,
    localparam int PAR_W  = par_w(DATA_W),
    localparam int HAM_W  = DATA_W + PAR_W,
    localparam int CODE_W = HAM_W + SECDED_W
) (
    input  logic [CODE_W-1:0] i_code,
`ifdef HAM_SECDED_EN
    output logic              o_par,
`endif
    output logic [PAR_W-1:0]  o_syn
);

    always_comb begin
        o_syn = '0;
        for (int i = 0; i < HAM_W; i++) begin
            for (int k = 0; k < PAR_W; k++) begin
                if ((((i + 1) >> k) & 1) != 0) begin
                    o_syn[k] = o_syn[k] ^ i_code[i];
                end
            end
        end
    end

`ifdef HAM_SECDED_EN
    assign o_par = ^i_code;
`endif

endmodule

// File: rtl/ham_secded_decoder.sv
// Two-stage pipelined Hamming decoder with valid/ready and saturating stats.
// HAM_SECDED_EN enables double-error detection via the overall parity bit.
module ham_secded_decoder
    import ham_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int CNT_W  = 16,
    localparam int PAR_W  = par_w(DATA_W),
    localparam int HAM_W  = DATA_W + PAR_W,
    localparam int CODE_W = HAM_W + SECDED_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] code_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output err_t              status,
    output logic [PAR_W-1:0]  err_pos,
    input  logic              count_clear,
    output logic [CNT_W-1:0]  corr_count,
    output logic [CNT_W-1:0]  uncorr_count
);

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;
    logic [PAR_W-1:0]  r_s1_syn;
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_s2_data;
    err_t              r_s2_status;
    logic [PAR_W-1:0]  r_s2_pos;
    logic [CNT_W-1:0]  r_corr;
    logic [CNT_W-1:0]  r_uncorr;

    logic [PAR_W-1:0]  w_syn;
    logic [DATA_W-1:0] w_in_data;
    logic [DATA_W-1:0] w_fix_data;
    logic              w_s1_move;
    logic              w_in_ready;
    logic              w_xfer;
    logic              w_flip;
    logic              w_in_range;
    err_t              w_status;

`ifdef HAM_SECDED_EN
    logic              w_par;
    logic              r_s1_par;

    ham_syndrome #(.DATA_W(DATA_W)) u_syn (
        .i_code (code_in),
        .o_par  (w_par),
        .o_syn  (w_syn)
    );
`else
    ham_syndrome #(.DATA_W(DATA_W)) u_syn (
        .i_code (code_in),
        .o_syn  (w_syn)
    );
`endif

    assign w_s1_move  = !r_s2_valid || out_ready;
    assign w_in_ready = !r_s1_valid || w_s1_move;
    assign w_xfer     = r_s2_valid && out_ready;

    always_comb begin
        w_in_data = '0;
        for (int d = 0; d < DATA_W; d++) begin
            w_in_data[d] = code_in[data_pos(d) - 1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_syn   <= '0;
`ifdef HAM_SECDED_EN
            r_s1_par   <= 1'b0;
`endif
        end else if (w_in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_data <= w_in_data;
                r_s1_syn  <= w_syn;
`ifdef HAM_SECDED_EN
                r_s1_par  <= w_par;
`endif
            end
        end
    end

    assign w_in_range = int'(r_s1_syn) <= HAM_W;

    always_comb begin
        w_flip   = 1'b0;
        w_status = ERR_NONE;
`ifdef HAM_SECDED_EN
        // s=0 with odd parity: only the overall parity bit flipped
        if (r_s1_syn == '0) begin
            w_status = r_s1_par ? ERR_CORR : ERR_NONE;
        end else if (r_s1_par && w_in_range) begin
            w_status = ERR_CORR;
            w_flip   = 1'b1;
        end else begin
            w_status = ERR_DOUBLE;
        end
`else
        if (r_s1_syn == '0) begin
            w_status = ERR_NONE;
        end else if (w_in_range) begin
            w_status = ERR_CORR;
            w_flip   = 1'b1;
        end else begin
            w_status = ERR_DOUBLE;
        end
`endif
    end

    always_comb begin
        w_fix_data = '0;
        for (int d = 0; d < DATA_W; d++) begin
            w_fix_data[d] = r_s1_data[d]
                ^ (w_flip && (int'(r_s1_syn) == data_pos(d)));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s2_valid  <= 1'b0;
            r_s2_data   <= '0;
            r_s2_status <= ERR_NONE;
            r_s2_pos    <= '0;
        end else if (w_s1_move) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data   <= w_fix_data;
                r_s2_status <= w_status;
                r_s2_pos    <= r_s1_syn;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || count_clear) begin
            r_corr   <= '0;
            r_uncorr <= '0;
        end else if (w_xfer) begin
            if (r_s2_status == ERR_CORR && r_corr != '1) begin
                r_corr <= r_corr + CNT_W'(1);
            end
            if (r_s2_status == ERR_DOUBLE && r_uncorr != '1) begin
                r_uncorr <= r_uncorr + CNT_W'(1);
            end
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = r_s2_valid;
    assign data_out     = r_s2_data;
    assign status       = r_s2_status;
    assign err_pos      = r_s2_pos;
    assign corr_count   = r_corr;
    assign uncorr_count = r_uncorr;

endmodule

// File: tb/tb_ham_secded_decoder.sv
// Directed bench for ham_secded_decoder at DATA_W=4, CNT_W=2.
// Expected values follow HAM_SECDED_EN when it is defined for the build.
module tb_ham_secded_decoder;
    import ham_pkg::*;

    localparam int DW   = 4;
    localparam int PW   = 3;
    localparam int CNTW = 2;
`ifdef HAM_SECDED_EN
    localparam int CW = 8;
`else
    localparam int CW = 7;
`endif

    logic            clock;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [CW-1:0]   code_in;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   data_out;
    err_t            status;
    logic [PW-1:0]   err_pos;
    logic            count_clear;
    logic [CNTW-1:0] corr_count;
    logic [CNTW-1:0] uncorr_count;

    int n_chk  = 0;
    int n_pass = 0;
    int e_corr = 0;
    int e_unc  = 0;

    ham_secded_decoder #(.DATA_W(DW), .CNT_W(CNTW)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .code_in      (code_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_out     (data_out),
        .status       (status),
        .err_pos      (err_pos),
        .count_clear  (count_clear),
        .corr_count   (corr_count),
        .uncorr_count (uncorr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v < 3) ? v + 1 : 3;
    endfunction

    // Reference encoder: positions 3,5,6,7 carry d0..d3
    function automatic logic [CW-1:0] enc(input logic [3:0] d);
        logic [7:0] c;
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[2] = d[0];
        c[3] = d[1] ^ d[2] ^ d[3];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        c[7] = ^c[6:0];
        return CW'(c);
    endfunction

    task automatic send_one(input string tag, input logic [7:0] raw,
                            input logic [3:0] ed, input err_t est,
                            input logic [2:0] epos);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        code_in   = CW'(raw);
        step();
        in_valid = 1'b0;
        check({tag, "_lat"}, 32'(out_valid), 32'd0);
        step();
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(data_out), 32'(ed));
        check({tag, "_st"}, 32'(status), 32'(est));
        check({tag, "_pos"}, 32'(err_pos), 32'(epos));
        step();
        if (est == ERR_CORR) e_corr = sat(e_corr);
        if (est == ERR_DOUBLE) e_unc = sat(e_unc);
        check({tag, "_cc"}, 32'(corr_count), 32'(e_corr));
        check({tag, "_uc"}, 32'(uncorr_count), 32'(e_unc));
    endtask

    logic [3:0] words [4];
    logic [3:0] got [$];
    int idx;
    int n_hold;
    int n_vld;

    initial begin
        words = '{4'h3, 4'hC, 4'h6, 4'h9};
        reset       = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        count_clear = 1'b0;
        code_in     = '0;
        repeat (3) step();
        check("rst_vld", 32'(out_valid), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_st", 32'(status), 32'(ERR_NONE));
        check("rst_pos", 32'(err_pos), 32'd0);
        check("rst_cc", 32'(corr_count), 32'd0);
        check("rst_uc", 32'(uncorr_count), 32'd0);
        reset = 1'b0;
        step();
        check("rdy_after_rst", 32'(in_ready), 32'd1);

        send_one("clean", 8'h55, 4'hB, ERR_NONE, 3'd0);
        send_one("pos5", 8'h45, 4'hB, ERR_CORR, 3'd5);
`ifdef HAM_SECDED_EN
        send_one("ovpar", 8'hD5, 4'hB, ERR_CORR, 3'd0);
        send_one("dbl", 8'h56, 4'hB, ERR_DOUBLE, 3'd3);
`else
        send_one("pos7", 8'h15, 4'hB, ERR_CORR, 3'd7);
        send_one("miscorr", 8'h56, 4'hA, ERR_CORR, 3'd3);
`endif

        count_clear = 1'b1;
        step();
        count_clear = 1'b0;
        e_corr = 0;
        e_unc  = 0;
        check("clr_cc", 32'(corr_count), 32'd0);
        check("clr_uc", 32'(uncorr_count), 32'd0);
        for (int i = 0; i < 5; i++) begin
            send_one($sformatf("sat%0d", i), 8'h45, 4'hB, ERR_CORR, 3'd5);
        end
        check("sat_cc", 32'(corr_count), 32'd3);

        // Clear lands on the same edge as a correcting transfer
        in_valid = 1'b1;
        code_in  = CW'(8'h45);
        step();
        in_valid = 1'b0;
        step();
        check("clrx_vld", 32'(out_valid), 32'd1);
        count_clear = 1'b1;
        step();
        count_clear = 1'b0;
        e_corr = 0;
        e_unc  = 0;
        check("clrx_cc", 32'(corr_count), 32'd0);
        check("clrx_vld2", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        idx    = 0;
        n_hold = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (idx < 4);
            code_in  = enc(idx < 4 ? words[idx] : 4'h0);
            #1;
            if (out_valid && data_out == words[0]) n_hold++;
            if (in_valid && in_ready) idx++;
            step();
        end
        check("bp_accepts", 32'(idx), 32'd2);
        check("bp_rdy", 32'(in_ready), 32'd0);
        check("bp_vld", 32'(out_valid), 32'd1);
        check("bp_data", 32'(data_out), 32'(words[0]));
        check("bp_hold", 32'(n_hold), 32'd3);

        out_ready = 1'b1;
        for (int c = 0; c < 15; c++) begin
            in_valid = (idx < 4);
            code_in  = enc(idx < 4 ? words[idx] : 4'h0);
            #1;
            if (out_valid && out_ready) got.push_back(data_out);
            if (in_valid && in_ready) idx++;
            step();
        end
        in_valid = 1'b0;
        check("bp_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_w%0d", i),
                  (got.size() > i) ? 32'(got[i]) : 32'hFFFF,
                  32'(words[i]));
        end
        check("bp_cc", 32'(corr_count), 32'(e_corr));

        // Mid-stream reset must drop both stages
        in_valid = 1'b1;
        code_in  = CW'(8'h45);
        step();
        step();
        check("mid_vld_pre", 32'(out_valid), 32'd1);
        reset    = 1'b1;
        in_valid = 1'b0;
        step();
        check("mid_rst_vld", 32'(out_valid), 32'd0);
        reset = 1'b0;
        n_vld = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (out_valid) n_vld++;
        end
        check("mid_no_out", 32'(n_vld), 32'd0);
        check("mid_cc", 32'(corr_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
